// File: rtl/vga_fetch_pkg.sv
// Shared types and constants for the VGA pixel fetch controller.
// Holds the FSM state encoding, bus widths and the default image clamps.
package vga_fetch_pkg;

    localparam int PIX_W     = 12;
    localparam int ADDR_W    = 19;
    localparam int DEF_MAX_W = 640;
    localparam int DEF_MAX_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    function automatic logic [15:0] clamp_dim(input logic [15:0] v, input int unsigned lim);
        return (32'(v) > lim) ? 16'(lim) : v;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead pixel FIFO with flush and occupancy count.
// The head is forced to zero while empty so the display sees black on underflow.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (r_count != (AW+1)'(DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/vga_pixel_fetch_ctrl.sv
// Fetches one frame of pixels from the frame buffer into a show-ahead FIFO
// that the VGA timing controller drains one pixel per iRequest.
module vga_pixel_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_W      = DEF_MAX_W,
    parameter int MAX_H      = DEF_MAX_H
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iFrameDone,
    input  logic        iRequest,
    input  logic [15:0] iVideo_W,
    input  logic [15:0] iVideo_H,
    input  logic [18:0] iBase_Addr,
    output logic        oMem_Req,
    output logic [18:0] oMem_Addr,
    input  logic        iMem_Ack,
    input  logic        iMem_Valid,
    input  logic [11:0] iMem_Data,
    output logic [3:0]  oRed,
    output logic [3:0]  oGreen,
    output logic [3:0]  oBlue,
    output logic        oUnderflow,
    output logic        oBusy,
    output logic [1:0]  oDbg_State
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Memory handshake: a request is transferred on any cycle where oMem_Req
    // and iMem_Ack are both high; oMem_Req/oMem_Addr hold until then. Read
    // beats (iMem_Valid) return in request order, one per cycle, no backpressure.

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;
    logic              r_underflow;

    logic [15:0]       w_width;
    logic [15:0]       w_height;
    logic [ADDR_W-1:0] w_total;
    logic              w_empty_frame;
    logic [CW:0]       w_in_flight;
    logic              w_mem_req;
    logic              w_ack;
    logic              w_beat;
    logic              w_push;
    logic [CW-1:0]     w_outstanding_nxt;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic [PIX_W-1:0]  w_head;

    assign w_width       = clamp_dim(iVideo_W, MAX_W);
    assign w_height      = clamp_dim(iVideo_H, MAX_H);
    assign w_total       = ADDR_W'(32'(w_width) * 32'(w_height));
    assign w_empty_frame = (w_width == '0) || (w_height == '0);

    // Credit check: every accepted read already owns a FIFO slot, so the FIFO cannot overflow.
    assign w_in_flight = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_mem_req   = (r_state == ST_FETCH) && (r_remaining != '0)
                      && (w_in_flight < (CW+1)'(FIFO_DEPTH));
    assign w_ack       = w_mem_req && iMem_Ack;

    // Beats arriving with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign w_beat            = iMem_Valid && (r_state != ST_IDLE) && (r_outstanding != '0);
    assign w_push            = w_beat && (r_discard == '0) && !iFrameDone;
    assign w_outstanding_nxt = r_outstanding + CW'(w_ack) - CW'(w_beat);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        oBusy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iFrameDone) w_state_nxt = w_empty_frame ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                oBusy = 1'b1;
                if (iFrameDone)
                    w_state_nxt = w_empty_frame ? ST_DONE : ST_FETCH;
                else if (w_ack && (r_remaining == ADDR_W'(1)))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (iFrameDone) w_state_nxt = w_empty_frame ? ST_DONE : ST_FETCH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A frame start orphans every read still in flight, including one acked this cycle.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_underflow   <= 1'b0;
        end else if (iFrameDone) begin
            r_addr        <= iBase_Addr;
            r_remaining   <= w_total;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_outstanding_nxt;
            r_underflow   <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_ack) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - ADDR_W'(1);
            end
            if (w_beat && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            if (iRequest && w_fifo_empty) r_underflow <= 1'b1;
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .i_clk   (iVGA_CLK),
        .i_rst_n (iRST_n),
        .i_flush (iFrameDone),
        .i_push  (w_push),
        .i_data  (iMem_Data),
        .i_pop   (iRequest && !iFrameDone),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign {oBlue, oGreen, oRed} = w_head;
    assign oMem_Req   = w_mem_req;
    assign oMem_Addr  = r_addr;
    assign oUnderflow = r_underflow;
    assign oDbg_State = r_state;

endmodule

// File: tb/tb_vga_pixel_fetch_ctrl.sv
// Bench for vga_pixel_fetch_ctrl: a memory responder, a queue-based frame model
// checked every cycle, a table of frame vectors and hand-written corner sequences.
module tb_vga_pixel_fetch_ctrl;
    import vga_fetch_pkg::*;

    localparam int DEPTH = 16;

    logic        iVGA_CLK   = 1'b0;
    logic        iRST_n     = 1'b0;
    logic        iFrameDone = 1'b0;
    logic        iRequest   = 1'b0;
    logic [15:0] iVideo_W   = '0;
    logic [15:0] iVideo_H   = '0;
    logic [18:0] iBase_Addr = '0;
    logic        iMem_Ack   = 1'b0;
    logic        iMem_Valid = 1'b0;
    logic [11:0] iMem_Data  = '0;
    logic        oMem_Req;
    logic [18:0] oMem_Addr;
    logic [3:0]  oRed, oGreen, oBlue;
    logic        oUnderflow, oBusy;
    logic [1:0]  oDbg_State;

    always #5 iVGA_CLK = ~iVGA_CLK;

    vga_pixel_fetch_ctrl dut (
        .iVGA_CLK   (iVGA_CLK),
        .iRST_n     (iRST_n),
        .iFrameDone (iFrameDone),
        .iRequest   (iRequest),
        .iVideo_W   (iVideo_W),
        .iVideo_H   (iVideo_H),
        .iBase_Addr (iBase_Addr),
        .oMem_Req   (oMem_Req),
        .oMem_Addr  (oMem_Addr),
        .iMem_Ack   (iMem_Ack),
        .iMem_Valid (iMem_Valid),
        .iMem_Data  (iMem_Data),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oUnderflow (oUnderflow),
        .oBusy      (oBusy),
        .oDbg_State (oDbg_State)
    );

    typedef struct {
        logic [18:0] addr;
        int          due;
    } rd_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [18:0] base;
        int          ack_mode;
        int          lat;
        int          pop_mode;
        int          exp_req;
        logic [18:0] exp_first;
        logic [18:0] exp_last;
        logic        exp_uf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus policy: ack_mode 0=always 1=random 2=never;
    // pop_mode 0=none 1=when pixel available 2=random 3=always 4=manual (rq_i)
    int          ack_mode = 0;
    int          lat      = 2;
    int          pop_mode = 0;
    logic        rq_i     = 1'b0;
    logic        fd_i     = 1'b0;
    logic [15:0] w_i      = '0;
    logic [15:0] h_i      = '0;
    logic [18:0] base_i   = '0;

    rd_t         mem_q[$];
    int          last_due = -1;
    int          dut_acks = 0;
    logic [18:0] req_addrs[$];
    logic [11:0] popped[$];

    // behavioural frame model
    fetch_state_e m_st   = ST_IDLE;
    logic [18:0]  m_addr = '0;
    int           m_rem  = 0;
    int           m_outs = 0;
    int           m_disc = 0;
    logic [11:0]  m_fifo[$];
    logic         m_uf   = 1'b0;

    vec_t vecs[6];

    function automatic logic [11:0] pix(input logic [18:0] a);
        return a[11:0] ^ {a[18:12], 5'b10110};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = ST_IDLE;
        m_addr = '0;
        m_rem  = 0;
        m_outs = 0;
        m_disc = 0;
        m_fifo.delete();
        m_uf   = 1'b0;
    endtask

    task automatic step();
        logic        req_pred;
        logic        ackf;
        logic        beat;
        logic        was_empty;
        logic [11:0] head;
        int          wc;
        int          hc;
        int          d;
        req_pred = (m_st == ST_FETCH) && (m_rem > 0) && ((m_fifo.size() + m_outs) < DEPTH);
        head     = (m_fifo.size() > 0) ? m_fifo[0] : 12'h0;
        chk("mem_req",   32'(oMem_Req), 32'(req_pred));
        chk("mem_addr",  32'(oMem_Addr), 32'(m_addr));
        chk("rgb",       32'({oBlue, oGreen, oRed}), 32'(head));
        chk("underflow", 32'(oUnderflow), 32'(m_uf));
        chk("busy",      32'(oBusy), 32'(m_st == ST_FETCH));
        chk("state",     32'(oDbg_State), 32'(m_st));

        iFrameDone = fd_i;
        iVideo_W   = w_i;
        iVideo_H   = h_i;
        iBase_Addr = base_i;
        case (pop_mode)
            1:       iRequest = (m_fifo.size() > 0);
            2:       iRequest = 1'($urandom_range(0, 1));
            3:       iRequest = 1'b1;
            4:       iRequest = rq_i;
            default: iRequest = 1'b0;
        endcase
        case (ack_mode)
            0:       iMem_Ack = 1'b1;
            1:       iMem_Ack = 1'($urandom_range(0, 1));
            default: iMem_Ack = 1'b0;
        endcase
        if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
            iMem_Valid = 1'b1;
            iMem_Data  = pix(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            iMem_Valid = 1'b0;
            iMem_Data  = 12'($urandom);
        end
        if (oMem_Req && iMem_Ack) begin
            d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_q.push_back('{oMem_Addr, d});
            last_due = d;
            dut_acks++;
            req_addrs.push_back(oMem_Addr);
        end
        if (iRequest && !fd_i && (m_fifo.size() > 0)) popped.push_back({oBlue, oGreen, oRed});

        ackf = req_pred && iMem_Ack;
        beat = iMem_Valid && (m_st != ST_IDLE) && (m_outs > 0);
        if (fd_i) begin
            wc     = (int'(w_i) > DEF_MAX_W) ? DEF_MAX_W : int'(w_i);
            hc     = (int'(h_i) > DEF_MAX_H) ? DEF_MAX_H : int'(h_i);
            m_rem  = wc * hc;
            m_addr = base_i;
            m_st   = (m_rem == 0) ? ST_DONE : ST_FETCH;
            m_outs = m_outs + int'(ackf) - int'(beat);
            m_disc = m_outs;
            m_fifo.delete();
            m_uf   = 1'b0;
        end else begin
            if (ackf) begin
                m_addr = m_addr + 19'd1;
                m_rem--;
                if (m_rem == 0) m_st = ST_DONE;
            end
            was_empty = (m_fifo.size() == 0);
            if (iRequest) begin
                if (was_empty) m_uf = 1'b1;
                else void'(m_fifo.pop_front());
            end
            if (beat) begin
                m_outs--;
                if (m_disc > 0) m_disc--;
                else m_fifo.push_back(iMem_Data);
            end
            if (ackf) m_outs++;
        end

        @(posedge iVGA_CLK);
        #1;
        cyc++;
        fd_i = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [18:0] base);
        w_i      = w;
        h_i      = h;
        base_i   = base;
        fd_i     = 1'b1;
        dut_acks = 0;
        req_addrs.delete();
        popped.delete();
        step();
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while (!((m_st != ST_FETCH) && (mem_q.size() == 0) && ((pop_mode == 0) || (m_fifo.size() == 0)))
               && (n < budget)) begin
            step();
            n++;
        end
        chk({"done_", name}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(oMem_Req), 32'd0);
        chk({tag, "_addr"},  32'(oMem_Addr), 32'd0);
        chk({tag, "_rgb"},   32'({oBlue, oGreen, oRed}), 32'd0);
        chk({tag, "_uf"},    32'(oUnderflow), 32'd0);
        chk({tag, "_busy"},  32'(oBusy), 32'd0);
        chk({tag, "_state"}, 32'(oDbg_State), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        #2;
        iRST_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge iVGA_CLK);
        #1;
        cyc++;
        iRST_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        logic [18:0] a;
        vecs[0] = '{16'd4,    16'd2,   19'h00100, 0, 2, 1, 8,    19'h00100, 19'h00107, 1'b0};
        vecs[1] = '{16'd1000, 16'd0,   19'h00010, 0, 1, 1, 0,    19'h00000, 19'h00000, 1'b0};
        vecs[2] = '{16'd1000, 16'd1,   19'h00000, 0, 1, 1, 640,  19'h00000, 19'h0027F, 1'b0};
        vecs[3] = '{16'd3,    16'd700, 19'h7FFFE, 1, 3, 1, 1440, 19'h7FFFE, 19'h0059D, 1'b0};
        vecs[4] = '{16'd5,    16'd5,   19'h01234, 1, 6, 1, 25,   19'h01234, 19'h0124C, 1'b0};
        vecs[5] = '{16'd17,   16'd1,   19'h40000, 0, 4, 3, 17,   19'h40000, 19'h40010, 1'b1};

        #1;
        check_reset_outputs("rst");
        @(posedge iVGA_CLK);
        #1;
        cyc = 1;
        iRST_n = 1'b1;
        repeat (3) step();

        // iRequest while idle and empty
        pop_mode = 4;
        rq_i = 1'b1;
        step();
        rq_i = 1'b0;
        step();
        chk("idle_uf", 32'(oUnderflow), 32'd1);
        chk("idle_rgb", 32'({oBlue, oGreen, oRed}), 32'd0);

        foreach (vecs[k]) begin
            ack_mode = vecs[k].ack_mode;
            lat      = vecs[k].lat;
            pop_mode = vecs[k].pop_mode;
            start_frame(vecs[k].w, vecs[k].h, vecs[k].base);
            run_until_done($sformatf("vec%0d", k), 6000);
            repeat (4) step();
            chk($sformatf("vec%0d_acks", k), 32'(dut_acks), 32'(vecs[k].exp_req));
            if (vecs[k].exp_req > 0 && req_addrs.size() > 0) begin
                chk($sformatf("vec%0d_first", k), 32'(req_addrs[0]), 32'(vecs[k].exp_first));
                chk($sformatf("vec%0d_last", k), 32'(req_addrs[req_addrs.size()-1]), 32'(vecs[k].exp_last));
            end
            chk($sformatf("vec%0d_npop", k), 32'(popped.size()), 32'(vecs[k].exp_req));
            bad = 0;
            for (int i = 0; i < popped.size(); i++) begin
                a = vecs[k].exp_first + 19'(i);
                if (popped[i] !== pix(a)) bad++;
            end
            chk($sformatf("vec%0d_order", k), 32'(bad), 32'd0);
            chk($sformatf("vec%0d_uf", k), 32'(oUnderflow), 32'(vecs[k].exp_uf));
            chk($sformatf("vec%0d_busy", k), 32'(oBusy), 32'd0);
        end

        // ack withheld: request and address must hold
        ack_mode = 2;
        pop_mode = 0;
        lat      = 2;
        start_frame(16'd8, 16'd1, 19'h02000);
        for (int i = 0; i < 20; i++) begin
            chk("hold_req", 32'(oMem_Req), 32'd1);
            chk("hold_addr", 32'(oMem_Addr), 32'h2000);
            chk("hold_rgb", 32'({oBlue, oGreen, oRed}), 32'd0);
            step();
        end
        ack_mode = 0;
        pop_mode = 1;
        run_until_done("hold", 500);
        chk("hold_acks", 32'(dut_acks), 32'd8);

        // full FIFO with no consumer, then a single pop
        ack_mode = 0;
        pop_mode = 0;
        lat      = 2;
        start_frame(16'd32, 16'd1, 19'h03000);
        repeat (30) step();
        chk("full_acks", 32'(dut_acks), 32'd16);
        chk("full_req", 32'(oMem_Req), 32'd0);
        pop_mode = 4;
        rq_i = 1'b1;
        step();
        rq_i = 1'b0;
        repeat (10) step();
        chk("full_pop_acks", 32'(dut_acks), 32'd17);
        chk("full_pop_req", 32'(oMem_Req), 32'd0);
        pop_mode = 1;
        run_until_done("full", 500);
        chk("full_total", 32'(dut_acks), 32'd32);

        // underflow is sticky until the next frame start
        pop_mode = 4;
        rq_i = 1'b1;
        step();
        rq_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("uf_sticky", 32'(oUnderflow), 32'd1);
            chk("uf_rgb", 32'({oBlue, oGreen, oRed}), 32'd0);
            step();
        end
        pop_mode = 1;
        start_frame(16'd2, 16'd1, 19'h00010);
        chk("uf_clear", 32'(oUnderflow), 32'd0);
        run_until_done("uf", 200);

        // restart with three reads in flight
        ack_mode = 0;
        pop_mode = 0;
        lat      = 6;
        start_frame(16'd16, 16'd1, 19'h00200);
        for (int n = 0; (n < 20) && (mem_q.size() < 3); n++) step();
        chk("disc_inflight", 32'(mem_q.size()), 32'd3);
        ack_mode = 2;
        start_frame(16'd4, 16'd1, 19'h00300);
        ack_mode = 0;
        for (int n = 0; (n < 30) && (m_fifo.size() == 0); n++) step();
        chk("disc_first", 32'({oBlue, oGreen, oRed}), 32'(pix(19'h00300)));
        pop_mode = 1;
        run_until_done("disc", 300);
        chk("disc_acks", 32'(dut_acks), 32'd4);
        chk("disc_npop", 32'(popped.size()), 32'd4);
        if (popped.size() > 0) chk("disc_pop0", 32'(popped[0]), 32'(pix(19'h00300)));

        // reset mid-frame: stale beats after release are ignored
        ack_mode = 0;
        pop_mode = 1;
        lat      = 5;
        start_frame(16'd20, 16'd1, 19'h00500);
        repeat (8) step();
        do_reset();
        pop_mode = 0;
        repeat (10) step();
        chk("postrst_rgb", 32'({oBlue, oGreen, oRed}), 32'd0);
        chk("postrst_state", 32'(oDbg_State), 32'(ST_IDLE));
        chk("postrst_req", 32'(oMem_Req), 32'd0);
        pop_mode = 1;
        start_frame(16'd2, 16'd2, 19'h00600);
        run_until_done("postrst", 300);
        chk("postrst_acks", 32'(dut_acks), 32'd4);

        // randomized frames, some abandoned mid-fetch
        for (int f = 0; f < 24; f++) begin
            logic [15:0] w;
            logic [15:0] h;
            ack_mode = 1;
            pop_mode = 2;
            lat      = $urandom_range(1, 6);
            w = 16'($urandom_range(0, 40));
            h = 16'($urandom_range(0, 3));
            if (f % 6 == 5) begin
                w = 16'd700;
                h = 16'd1;
            end
            start_frame(w, h, 19'($urandom));
            if (f % 4 == 3) repeat ($urandom_range(2, 15)) step();
            else run_until_done($sformatf("rand%0d", f), 4000);
        end
        run_until_done("rand_tail", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
